// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Shared types and constants for the Sobel stream filter.
package sobel_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } sobel_state_e;

  localparam int SOBEL_W_EDGE = 1;
  localparam int SOBEL_W_MID  = 2;

  function automatic int sobel_grad_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - One-line pixel store, asynchronous read, synchronous write.
module sobel_line_buffer #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read sees the old word when the same address is written this cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - Sobel edge filter on a raster pixel stream.
// Define SOBEL_MAG_OUT_EN for saturated magnitude output instead of a thresholded edge map.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COLS   = 512,
  parameter int ROWS   = 512,
  parameter int THRESH = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             frame_err
);

  localparam int GW = sobel_grad_w(PIX_W);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL2 = CW'(2);
  localparam logic [RW-1:0] ROW2 = RW'(2);
  localparam logic signed [GW-1:0] WE = GW'(SOBEL_W_EDGE);
  localparam logic signed [GW-1:0] WM = GW'(SOBEL_W_MID);

  sobel_state_e     state_q, state_d;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic             accept, restart, err_d, qual, qual_sof;
  logic [PIX_W-1:0] lb_prev, lb_prev2;
  logic [PIX_W-1:0] win [3][3];
  logic signed [GW-1:0] gx_q, gy_q;
  logic [GW-1:0]    ax, ay, mag;
  logic [PIX_W-1:0] pix_d;
  logic             v1, s1, v2, s2;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = 1'b0;
    restart = 1'b0;
    err_d   = 1'b0;
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          if (in_sof) accept = 1'b1;
          else if (state_q == S_DONE) err_d = 1'b1;
        end
      end
      default: begin
        if (in_valid) begin
          accept = 1'b1;
          // A mid-frame sof restarts the frame at this pixel.
          if (in_sof && (col_q != '0 || row_q != '0)) begin
            err_d   = 1'b1;
            restart = 1'b1;
          end
        end
      end
    endcase
    if (accept) begin
      col_d = (cur_col == LAST_COL) ? '0 : cur_col + CW'(1);
      row_d = (cur_col == LAST_COL) ? cur_row + RW'(1) : cur_row;
      if (cur_col == LAST_COL && cur_row == LAST_ROW) begin
        row_d   = '0;
        state_d = S_DONE;
      end else begin
        state_d = (row_d < ROW2) ? S_FILL : S_RUN;
      end
    end
    qual     = accept && cur_row >= ROW2 && cur_col >= COL2;
    qual_sof = qual && cur_row == ROW2 && cur_col == COL2;
  end

  sobel_line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W), .AW(CW)) u_lb_prev (
    .clk(clk), .wr_en(accept), .wr_addr(cur_col), .wr_data(in_pixel),
    .rd_addr(cur_col), .rd_data(lb_prev)
  );

  sobel_line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W), .AW(CW)) u_lb_prev2 (
    .clk(clk), .wr_en(accept), .wr_addr(cur_col), .wr_data(lb_prev),
    .rd_addr(cur_col), .rd_data(lb_prev2)
  );

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GW-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic signed [GW-1:0] tri3(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
    return WE * ext(a) + WM * ext(b) + WE * ext(c);
  endfunction

  // win[0] is row r-2, win[2] the incoming row; column 2 is the newest.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= (cur_col == '0) ? '0 : win[r][1];
        win[r][1] <= (cur_col == '0) ? '0 : win[r][2];
      end
      win[0][2] <= lb_prev2;
      win[1][2] <= lb_prev;
      win[2][2] <= in_pixel;
    end
    gx_q <= tri3(win[0][2], win[1][2], win[2][2]) - tri3(win[0][0], win[1][0], win[2][0]);
    gy_q <= tri3(win[2][0], win[2][1], win[2][2]) - tri3(win[0][0], win[0][1], win[0][2]);
  end

`ifdef SOBEL_MAG_OUT_EN
  localparam logic [GW-1:0] PIX_MAX = GW'((1 << PIX_W) - 1);
`else
  localparam logic [GW-1:0] THR = GW'(THRESH);
`endif

  always_comb begin
    ax  = gx_q[GW-1] ? -gx_q : gx_q;
    ay  = gy_q[GW-1] ? -gy_q : gy_q;
    mag = ax + ay;
`ifdef SOBEL_MAG_OUT_EN
    pix_d = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
`else
    pix_d = (mag > THR) ? {PIX_W{1'b1}} : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      v1        <= 1'b0;
      s1        <= 1'b0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      frame_err <= err_d;
      v1        <= qual;
      s1        <= qual_sof;
      v2        <= v1 && !restart;
      s2        <= s1;
      out_valid <= v2 && !restart;
      out_sof   <= v2 && s2 && !restart;
      if (v2) out_pixel <= pix_d;
    end
  end

endmodule
